// File: rtl/decoded_inst_buffer_pkg.sv
// Shared decoded-instruction bundle definition, used by the decode buffer, dispatch and
// the reservation stations.
package decoded_inst_buffer_pkg;

  localparam int OPC_W    = 12;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;
  localparam int ADDR_W   = 26;
  localparam int PC_W     = 32;
  localparam int BUNDLE_W = OPC_W + 4*REG_W + IMM_W + ADDR_W + PC_W;

  // hlt: op = 6'h3F, funct field zero
  localparam logic [OPC_W-1:0] HLT_OPCODE = 12'hFC0;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [IMM_W-1:0]  immediate;
    logic [ADDR_W-1:0] address;
    logic [PC_W-1:0]   pc;
  } bundle_t;

  function automatic logic [BUNDLE_W-1:0] pack_bundle(
    input logic [OPC_W-1:0]  opcode,
    input logic [REG_W-1:0]  rs,
    input logic [REG_W-1:0]  rt,
    input logic [REG_W-1:0]  rd,
    input logic [REG_W-1:0]  shamt,
    input logic [IMM_W-1:0]  immediate,
    input logic [ADDR_W-1:0] address,
    input logic [PC_W-1:0]   pc
  );
    return {opcode, rs, rt, rd, shamt, immediate, address, pc};
  endfunction

  function automatic bundle_t unpack_bundle(input logic [BUNDLE_W-1:0] bits);
    return bundle_t'(bits);
  endfunction

endpackage

// File: rtl/decoded_inst_buffer_sync_fifo_ptr.sv
// Pointer/occupancy bookkeeping for a DEPTH-entry circular FIFO; updates one cycle after push/pop.
// Push is ignored when full and pop when empty; clr empties the FIFO and wins over push/pop.
module sync_fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic do_push;
  logic do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the natural pointer overflow is the wrap
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoded_inst_buffer.sv
// In-order decoupling buffer between decode and dispatch; push-to-head latency 1 cycle, no bypass.
// in_ready/stall depend only on registered state (full or halted); flush discards everything.
module decoded_inst_buffer #(
  parameter int          DEPTH      = 8,
  parameter int          PTR_W      = 3,
  parameter logic [11:0] HLT_OPCODE = decoded_inst_buffer_pkg::HLT_OPCODE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [11:0]    in_opcode,
  input  logic [4:0]     in_rs,
  input  logic [4:0]     in_rt,
  input  logic [4:0]     in_rd,
  input  logic [4:0]     in_shamt,
  input  logic [15:0]    in_immediate,
  input  logic [25:0]    in_address,
  input  logic [31:0]    in_pc,
  output logic           in_ready,
  output logic           stall,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [11:0]    out_opcode,
  output logic [4:0]     out_rs,
  output logic [4:0]     out_rt,
  output logic [4:0]     out_rd,
  output logic [4:0]     out_shamt,
  output logic [15:0]    out_immediate,
  output logic [25:0]    out_address,
  output logic [31:0]    out_pc,
  input  logic           flush,
  output logic           halted,
  output logic [PTR_W:0] count
);

  import decoded_inst_buffer_pkg::*;

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [BUNDLE_W-1:0] in_bits;
  logic [BUNDLE_W-1:0] mem [DEPTH];
  logic [BUNDLE_W-1:0] last_q;
  logic [BUNDLE_W-1:0] head_bits;
  bundle_t             head;

  assign in_ready  = !full && !halted;
  assign stall     = !in_ready;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign in_bits = pack_bundle(in_opcode, in_rs, in_rt, in_rd, in_shamt,
                               in_immediate, in_address, in_pc);

  // Storage is deliberately not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bits;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      halted <= 1'b0;
    end else if (push && (in_opcode == HLT_OPCODE)) begin
      halted <= 1'b1;
    end
  end

  // Empty buffer re-presents the last head so stale or unwritten storage never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (out_valid) begin
      last_q <= mem[rd_ptr];
    end
  end

  assign head_bits = out_valid ? mem[rd_ptr] : last_q;
  assign head      = unpack_bundle(head_bits);

  assign out_opcode    = head.opcode;
  assign out_rs        = head.rs;
  assign out_rt        = head.rt;
  assign out_rd        = head.rd;
  assign out_shamt     = head.shamt;
  assign out_immediate = head.immediate;
  assign out_address   = head.address;
  assign out_pc        = head.pc;

endmodule

// File: tb/tb_decoded_inst_buffer.sv
// Randomized and directed bench for decoded_inst_buffer against a queue-based reference model.
module tb_decoded_inst_buffer;
  import decoded_inst_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [11:0] OPC_ADDI = 12'h200;
  localparam logic [11:0] OPC_SW   = 12'hAC0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_opcode = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_immediate = '0;
  logic [25:0] in_address = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready, stall, out_valid, halted;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_immediate;
  logic [25:0] out_address;
  logic [31:0] out_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  bundle_t q[$];
  bit      halted_m = 1'b0;
  bundle_t shown = '0;
  int      pc_ctr = 0;

  always #5 clk = ~clk;

  decoded_inst_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_immediate(in_immediate), .in_address(in_address), .in_pc(in_pc),
    .in_ready(in_ready), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_immediate(out_immediate), .out_address(out_address),
    .out_pc(out_pc), .flush(flush), .halted(halted), .count(count)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bundle_t obs;
    bundle_t exp_b;
    bit      exp_rdy;
    exp_rdy = (q.size() < DEPTH) && !halted_m;
    check_eq("count", 128'(count), 128'(q.size()));
    check_eq("in_ready", 128'(in_ready), 128'(exp_rdy));
    check_eq("stall", 128'(stall), 128'(!exp_rdy));
    check_eq("out_valid", 128'(out_valid), 128'(q.size() > 0));
    check_eq("halted", 128'(halted), 128'(halted_m));
    obs = unpack_bundle(pack_bundle(out_opcode, out_rs, out_rt, out_rd, out_shamt,
                                    out_immediate, out_address, out_pc));
    exp_b = (q.size() > 0) ? q[0] : shown;
    check_eq("head", 128'(obs), 128'(exp_b));
    if (q.size() > 0) shown = q[0];
  endtask

  // Called at a negedge: drives one cycle, advances the model across the posedge, checks at the next negedge.
  task automatic drive(input bit v, input logic [11:0] opc, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit r);
    bundle_t b;
    bit      do_push;
    bit      do_pop;
    b.opcode    = opc;
    b.rs        = 5'($urandom);
    b.rt        = 5'($urandom);
    b.rd        = 5'($urandom);
    b.shamt     = 5'($urandom);
    b.immediate = 16'($urandom);
    b.address   = 26'($urandom);
    b.pc        = pc;
    in_valid = v; in_opcode = b.opcode; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd;
    in_shamt = b.shamt; in_immediate = b.immediate; in_address = b.address; in_pc = b.pc;
    out_ready = ordy; flush = fl; rst = r;

    if (r) begin
      q.delete();
      halted_m = 1'b0;
      shown = '0;
    end else if (fl) begin
      q.delete();
      halted_m = 1'b0;
    end else begin
      do_push = v && (q.size() < DEPTH) && !halted_m;
      do_pop  = (q.size() > 0) && ordy;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(b);
        if (opc == HLT_OPCODE) halted_m = 1'b1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    drive(0, '0, 0, 0, 0, 1);

    // fill to full, ninth push refused, drain in order
    for (int i = 0; i < 9; i++) drive(1, OPC_ADDI, 32'(i), 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, OPC_ADDI, 0, 1, 0, 0);

    // empty + push with out_ready: no bypass
    drive(1, OPC_ADDI, 5, 1, 0, 0);
    drive(0, OPC_ADDI, 0, 1, 0, 0);

    // steady push+pop at count 3, pointers wrap
    for (int i = 0; i < 3; i++) drive(1, OPC_ADDI, 32'(i), 0, 0, 0);
    for (int i = 3; i < 23; i++) drive(1, OPC_ADDI, 32'(i), 1, 0, 0);
    drive(0, '0, 0, 0, 1, 0);

    // hlt stops further pushes; hlt itself is dispatched
    drive(1, OPC_ADDI, 100, 0, 0, 0);
    drive(1, HLT_OPCODE, 101, 0, 0, 0);
    drive(1, OPC_SW, 102, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, OPC_SW, 103, 1, 0, 0);
    drive(0, '0, 0, 0, 1, 0);

    // flush with simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) drive(1, OPC_ADDI, 32'(200 + i), 0, 0, 0);
    drive(1, OPC_ADDI, 205, 1, 1, 0);
    drive(1, OPC_ADDI, 206, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0);

    // reset beats flush and push while halted mid-fill
    for (int i = 0; i < 3; i++) drive(1, OPC_ADDI, 32'(300 + i), 0, 0, 0);
    drive(1, HLT_OPCODE, 303, 0, 0, 0);
    drive(1, OPC_ADDI, 304, 1, 1, 1);
    drive(1, OPC_ADDI, 305, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      logic [11:0] opc;
      opc = ($urandom_range(0, 99) < 5) ? HLT_OPCODE : 12'($urandom);
      drive($urandom_range(0, 99) < 70, opc, 32'(pc_ctr), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
      pc_ctr++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoded_inst_buffer.md
Name: decoded_inst_buffer

Overview:
- Decoupling FIFO directly downstream of the instruction-fetch/decode stage.
- Captures each decoded instruction bundle (opcode, rs, rt, rd, shamt, immediate, address, pc) and presents it in order to the dispatch/rename stage through a valid/ready handshake.
- Provides back-pressure to the PC logic (stall), drops wrong-path instructions on flush, and detects hlt so fetch stops feeding the core.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- PTR_W, 3, log2(DEPTH); pointer width.
- HLT_OPCODE, 12'hFC0, packed 12-bit opcode of hlt (upper 6 = 6'h3F, lower 6 = 0).

Ports:
- clk  in  1  single core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode bundle valid (driven from VALID_Inst).
- in_opcode  in  12  packed opcode {op[5:0], funct-or-zero}.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shamt fields.
- in_immediate  in  16  immediate field.
- in_address  in  26  jump target field.
- in_pc  in  32  instruction word index.
- in_ready  out  1  buffer accepts a push this cycle.
- stall  out  1  equals !in_ready; PC generator holds PC.
- out_valid  out  1  head entry present.
- out_ready  in  1  dispatch consumes head this cycle.
- out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address, out_pc  out  same widths  head entry fields.
- flush  in  1  mispredict/redirect; discard all entries.
- halted  out  1  hlt captured; no further pushes.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (sync, posedge with rst=1): wr_ptr=rd_ptr=0, count=0, halted=0, out_valid=0, in_ready=1, stall=0, all out_* fields=0. Storage array is not cleared. Reset mid-operation discards all entries identically.
- Upstream fields change on negedge; they are stable at the posedge sample point.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & !halted. It is registered-state-derived only, with no combinational path from out_ready. A full buffer with simultaneous pop still refuses the push.
- Push: entry[wr_ptr] <= bundle; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop: rd_ptr <= rd_ptr+1, wrapping.
- Occupancy: push&pop gives count unchanged; push only gives +1; pop only gives −1.
- Empty + push: no bypass. out_valid rises the next cycle (latency 1 cycle from push to head).
- out_* = entry[rd_ptr] combinationally. out_valid = (count != 0). Fields are don't-care when out_valid=0, but hold last value (no X-propagation in sim).
- Pop when empty: impossible by definition; out_ready is ignored.
- hlt: a push whose in_opcode == HLT_OPCODE sets halted next cycle. The hlt entry itself is stored and dispatched normally. Later pushes are blocked (in_ready=0) until flush or rst.
- flush: highest priority after rst. Next cycle: count=0, wr_ptr=rd_ptr=0, halted=0. Any push/pop in the flush cycle is discarded. rst has priority over flush.
- No state machine beyond halted flag. States: RUN(halted=0) → HALT on hlt push; HALT → RUN on flush/rst.

Decomposition:
- Shared package: HLT_OPCODE, the opcode field width (12), the decoded bundle struct/width (106 bits: 12+5*4+16+26+32) with pack/unpack functions. The same bundle is used by dispatch and reservation stations.
- One sub-module is natural: sync_fifo_ptr (pointer/count/full/empty logic, parameterized DEPTH). The top level adds the bundle storage, hlt detection and flush.

Test Plan:
- Reset then 8 consecutive pushes (pc 0..7), out_ready=0 → count=8, in_ready=0, stall=1. The 9th push (pc 8) is ignored. Draining yields pc 0..7 in order.
- Empty buffer, push pc=5 with out_ready=1 the same cycle → out_valid=0 that cycle, out_valid=1 with out_pc=5 next cycle, count=1.
- Continuous push+pop for 20 cycles starting at count=3 → count stays 3, pointers wrap past 7→0, output order equals input order (pc 0..19).
- Push addi (opcode 12'h200), then hlt (12'hFC0), then sw (12'hAC0) → hlt stored, halted=1 the cycle after, in_ready=0, sw not stored. Drain gives 12'h200, 12'hFC0 only.
- count=5, assert flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, halted=0. The flush-cycle push is discarded. A push the following cycle appears at the head.
- Mid-fill (count=4, halted=1), assert rst together with flush and push → next cycle all outputs at reset values, in_ready=1.
